// File: rtl/disp_pkg.sv
// Shared constants and scan-state type for the seven-segment display path.
package disp_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/refresh_timer.sv
// Slot timer for the display scan: cycle counter, slot index and blank/drive phasing.
module refresh_timer
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] slot,
    output logic       capture,
    output logic       slot_end
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    scan_state_t      state_q;
    scan_state_t      state_d;

    // Free-running slot counter; slot index advances on every wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            slot <= '0;
        end else if (slot_end) begin
            cnt  <= '0;
            slot <= slot + 2'd1;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    // Scan phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase transitions and the capture/slot-end pulses.
    always_comb begin
        state_d  = state_q;
        capture  = (cnt == CNT_CAP);
        slot_end = (cnt == CNT_LAST);
        case (state_q)
            BLANK: if (capture)  state_d = DRIVE;
            DRIVE: if (slot_end) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed four-digit common-anode display driver with per-slot blanking.
module seg_display_mux
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned DOT_DIGIT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [6:0] seg4,
    input  logic       dot,
    input  logic       disp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    logic [1:0] slot;
    logic       capture;
    logic       slot_end;
    logic [6:0] seg_sel;
    logic [3:0] an_sel;
    logic       dp_sel;

    refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .slot     (slot),
        .capture  (capture),
        .slot_end (slot_end)
    );

    // Select the pattern, anode and decimal point for the current slot.
    always_comb begin
        seg_sel = SEG_OFF;
        case (slot)
            2'd0: seg_sel = seg1;
            2'd1: seg_sel = seg2;
            2'd2: seg_sel = seg3;
            2'd3: seg_sel = seg4;
            default: seg_sel = SEG_OFF;
        endcase
        an_sel = disp_en ? ~(4'(1 << (NUM_DIGITS - 1)) >> slot) : AN_OFF;
        dp_sel = (dot && (slot == 2'(DOT_DIGIT))) ? 1'b0 : 1'b1;
    end

    // Output registers: blank at slot end, load the captured digit after the blank phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (slot_end) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (capture) begin
            an  <= an_sel;
            seg <= seg_sel;
            dp  <= dp_sel;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_display_mux;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         gap;   // expected all-off cycles before this drive, -1 = don't check
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg1 = 7'h40;
    logic [6:0] seg2 = 7'h79;
    logic [6:0] seg3 = 7'h24;
    logic [6:0] seg4 = 7'h30;
    logic       dot = 1'b1;
    logic       disp_en = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seg_display_mux #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .DOT_DIGIT    (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3),
        .seg4    (seg4),
        .dot     (dot),
        .disp_en (disp_en),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int g);
        exp_t e;
        e.an = a; e.seg = s; e.dp = d; e.gap = g;
        q.push_back(e);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation at each drive start, checks hold, width, gap and one-hot.
    initial begin : monitor
        exp_t cur;
        bit   in_drive = 1'b0;
        int   drive_len = 0;
        int   off_cnt = 0;
        int   zeros;
        cur.an = 4'hF; cur.seg = 7'h7F; cur.dp = 1'b1; cur.gap = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_drive  = 1'b0;
                drive_len = 0;
                off_cnt   = 0;
            end else if (an != 4'hF) begin
                zeros = 0;
                for (int i = 0; i < 4; i++) if (!an[i]) zeros++;
                check("an_onehot_low", zeros, 1);
                if (!in_drive) begin
                    if (q.size() == 0) begin
                        check("unexpected_drive", int'(an), 15);
                    end else begin
                        cur = q.pop_front();
                        if (cur.gap >= 0) check("blank_gap", off_cnt, cur.gap);
                    end
                    in_drive  = 1'b1;
                    drive_len = 0;
                end
                drive_len++;
                check("an",  int'(an),  int'(cur.an));
                check("seg", int'(seg), int'(cur.seg));
                check("dp",  int'(dp),  int'(cur.dp));
            end else begin
                if (in_drive) begin
                    check("drive_width", drive_len, 6);
                    in_drive = 1'b0;
                    off_cnt  = 0;
                end
                off_cnt++;
            end
        end
    end

    // Stimulus: directed frames with hand-computed expected drives.
    initial begin : stim
        // frame 1: seg1 changes mid slot 0, still shows 0x40
        push(4'h7, 7'h40, 1'b1, -1);
        push(4'hB, 7'h79, 1'b1, 2);
        push(4'hD, 7'h24, 1'b0, 2);
        push(4'hE, 7'h30, 1'b1, 2);
        // frame 2: new seg1 picked up
        push(4'h7, 7'h79, 1'b1, 2);
        push(4'hB, 7'h79, 1'b1, 2);
        push(4'hD, 7'h24, 1'b0, 2);
        push(4'hE, 7'h30, 1'b1, 2);
        // frame 3: slot 2 disabled, so slot 3 follows a 10-cycle gap
        push(4'h7, 7'h79, 1'b1, 2);
        push(4'hB, 7'h79, 1'b1, 2);
        push(4'hE, 7'h30, 1'b1, 10);
        // frame 4
        push(4'h7, 7'h79, 1'b1, 2);
        push(4'hB, 7'h79, 1'b1, 2);
        push(4'hD, 7'h24, 1'b0, 2);
        push(4'hE, 7'h30, 1'b1, 2);
        // frame 5: reset lands inside slot 1 drive
        push(4'h7, 7'h79, 1'b1, 2);
        push(4'hB, 7'h79, 1'b1, 2);
        // frame after reset
        push(4'h7, 7'h79, 1'b1, -1);
        push(4'hB, 7'h79, 1'b1, 2);
        push(4'hD, 7'h24, 1'b0, 2);
        push(4'hE, 7'h30, 1'b1, 2);

        edges(3);
        check("rst_an",  int'(an),  15);
        check("rst_seg", int'(seg), 'h7F);
        check("rst_dp",  int'(dp),  1);
        reset = 1'b0;                  // release: edge count restarts here

        edges(4);                      // cnt = 4 in slot 0
        seg1 = 7'h79;
        edges(76);                     // edge 80: slot 2 of frame 3 starts
        disp_en = 1'b0;
        edges(2);                      // edge 82: slot 2 capture done with disp_en=0
        disp_en = 1'b1;
        edges(1);
        check("dis_an",  int'(an),  15);
        check("dis_seg", int'(seg), 'h24);
        check("dis_dp",  int'(dp),  0);
        edges(57);                     // edge 140: mid slot 1 drive of frame 5
        check("pre_rst_an", int'(an), 'hB);
        reset = 1'b1;
        #1;
        check("async_rst_an",  int'(an),  15);
        check("async_rst_seg", int'(seg), 'h7F);
        check("async_rst_dp",  int'(dp),  1);
        edges(2);
        reset = 1'b0;
        edges(1);
        check("post_rst_e1_an", int'(an), 15);
        edges(1);
        check("post_rst_e2_an", int'(an), 7);
        edges(5);
        check("post_rst_e7_an", int'(an), 7);
        edges(1);
        check("post_rst_e8_an", int'(an), 15);
        edges(25);                     // edge 33, before next frame drive at 34
        #5;
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
